// File: rtl/instr_encoder_pkg.sv
// Shared types and constants for the instruction encoder / program loader.
package instr_encoder_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned ERR_W = 2;

    // Immediate format selects (shared with the immediate generator)
    localparam logic [SEL_W-1:0] IMM_I  = 3'b000;
    localparam logic [SEL_W-1:0] IMM_S  = 3'b001;
    localparam logic [SEL_W-1:0] IMM_B  = 3'b010;
    localparam logic [SEL_W-1:0] IMM_U  = 3'b011;
    localparam logic [SEL_W-1:0] IMM_J  = 3'b100;
    localparam logic [SEL_W-1:0] IMM_R  = 3'b101;
    localparam logic [SEL_W-1:0] IMM_NF = 3'b111;

    // Sticky error codes
    localparam logic [ERR_W-1:0] ERR_NONE  = 2'b00;
    localparam logic [ERR_W-1:0] ERR_SEL   = 2'b01;
    localparam logic [ERR_W-1:0] ERR_RANGE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FULL = 2'b10
    } enc_state_t;

    // Decoded field bundle handed to the packer
    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic [6:0]       opcode;
        logic [4:0]       rd;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [2:0]       funct3;
        logic [6:0]       funct7;
        logic [XLEN-1:0]  imm;
    } instr_fields_t;

endpackage

// File: rtl/instr_encoder_imm_pack.sv
// Combinational packer: decoded fields + immediate -> RV32I word.
// Optional immediate range checking is enabled with IMM_RANGE_CHECK_EN.
module instr_encoder_imm_pack
    import instr_encoder_pkg::*;
(
    input  instr_fields_t   fields,
    output logic [XLEN-1:0] word_c,
    output logic            sel_err_c,
    output logic            range_err_c
);

    logic [XLEN-1:0] imm;
    assign imm = fields.imm;

    // Scatter the immediate into the format-specific bit positions
    always_comb begin
        word_c    = '0;
        sel_err_c = 1'b0;
        case (fields.sel)
            IMM_I: word_c = {imm[11:0], fields.rs1, fields.funct3, fields.rd, fields.opcode};
            IMM_S: word_c = {imm[11:5], fields.rs2, fields.rs1, fields.funct3, imm[4:0],
                             fields.opcode};
            IMM_B: word_c = {imm[12], imm[10:5], fields.rs2, fields.rs1, fields.funct3,
                             imm[4:1], imm[11], fields.opcode};
            IMM_U: word_c = {imm[31:12], fields.rd, fields.opcode};
            IMM_J: word_c = {imm[20], imm[10:1], imm[11], imm[19:12], fields.rd,
                             fields.opcode};
            IMM_R: word_c = {fields.funct7, fields.rs2, fields.rs1, fields.funct3, fields.rd,
                             fields.opcode};
            default: sel_err_c = 1'b1;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // Flag immediates that would not survive the round trip through imm_gen
    always_comb begin
        range_err_c = 1'b0;
        case (fields.sel)
            IMM_I, IMM_S: range_err_c = (imm[31:11] != {21{imm[11]}});
            IMM_B:        range_err_c = (imm[31:12] != {20{imm[12]}}) || imm[0];
            IMM_J:        range_err_c = (imm[31:20] != {12{imm[20]}}) || imm[0];
            IMM_U:        range_err_c = (imm[11:0] != 12'h000);
            default:      range_err_c = 1'b0;
        endcase
    end
`else
    assign range_err_c = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder / program loader: packs accepted field bundles and
// writes them to consecutive program-memory addresses one cycle later.
// Optional macro: IMM_RANGE_CHECK_EN (reject out-of-range immediates).
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_imm_sel,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_SLOT = {1'b0, {ADDR_W{1'b1}}};

    enc_state_t      state, state_next;
    instr_fields_t   fields;
    logic [XLEN-1:0] word_c;
    logic            sel_err_c;
    logic            range_err_c;
    logic            take_c;
    logic            write_c;
    logic            bad_c;

    assign fields = '{sel:    in_imm_sel,
                      opcode: in_opcode,
                      rd:     in_rd,
                      rs1:    in_rs1,
                      rs2:    in_rs2,
                      funct3: in_funct3,
                      funct7: in_funct7,
                      imm:    in_imm};

    instr_encoder_imm_pack u_imm_pack (
        .fields      (fields),
        .word_c      (word_c),
        .sel_err_c   (sel_err_c),
        .range_err_c (range_err_c)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next state and handshake decode; start always wins and refuses the transfer
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        take_c     = 1'b0;
        write_c    = 1'b0;
        bad_c      = 1'b0;
        case (state)
            ST_RUN: begin
                in_ready = !start;
                take_c   = in_valid && !start;
                bad_c    = take_c && (sel_err_c || range_err_c);
                write_c  = take_c && !sel_err_c && !range_err_c;
                if (write_c && (count == LAST_SLOT)) state_next = ST_FULL;
            end
            ST_IDLE, ST_FULL: state_next = state;
            default:          state_next = ST_IDLE;
        endcase
        if (start) state_next = ST_RUN;
    end

    // Output register, write counter and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            count     <= '0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            mem_we <= write_c;
            if (start) begin
                count    <= '0;
                err      <= 1'b0;
                err_code <= ERR_NONE;
            end else begin
                if (write_c) begin
                    mem_addr  <= count[ADDR_W-1:0];
                    mem_wdata <= word_c;
                    count     <= count + CNT_W'(1);
                end
                if (bad_c && !err) begin
                    err      <= 1'b1;
                    err_code <= sel_err_c ? ERR_SEL : ERR_RANGE;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_instr_encoder;

    localparam int unsigned AW  = 2;
    localparam int          CAP = 1 << AW;
    localparam int          NV  = 7;

    typedef struct {
        logic [2:0]  sel;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] word;
    } vec_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_imm_sel;
    logic [6:0]    in_opcode;
    logic [4:0]    in_rd;
    logic [4:0]    in_rs1;
    logic [4:0]    in_rs2;
    logic [2:0]    in_funct3;
    logic [6:0]    in_funct7;
    logic [31:0]   in_imm;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   count;
    logic          err;
    logic [1:0]    err_code;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    bit         m_run   = 0;
    int         m_count = 0;
    bit         m_err   = 0;
    logic [1:0] m_code  = 2'b00;

    vec_t tbl [NV];
    vec_t idle_v;
    vec_t v_tmp;

    instr_encoder #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_imm_sel (in_imm_sel),
        .in_opcode  (in_opcode),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_funct3  (in_funct3),
        .in_funct7  (in_funct7),
        .in_imm     (in_imm),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .count      (count),
        .err        (err),
        .err_code   (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference packing built from shifts and masks of the field values
    function automatic logic [31:0] ref_word(input vec_t v);
        logic [31:0] base;
        logic [31:0] i;
        i    = v.imm;
        base = 32'(v.op) | (32'(v.f3) << 12) | (32'(v.rs1) << 15);
        case (v.sel)
            3'd0: return base | (32'(v.rd) << 7) | ((i & 32'hFFF) << 20);
            3'd1: return base | (32'(v.rs2) << 20) | ((i & 32'h1F) << 7)
                         | (((i >> 5) & 32'h7F) << 25);
            3'd2: return base | (32'(v.rs2) << 20) | (((i >> 12) & 32'h1) << 31)
                         | (((i >> 5) & 32'h3F) << 25) | (((i >> 1) & 32'hF) << 8)
                         | (((i >> 11) & 32'h1) << 7);
            3'd3: return 32'(v.op) | (32'(v.rd) << 7) | (i & 32'hFFFFF000);
            3'd4: return 32'(v.op) | (32'(v.rd) << 7) | (((i >> 20) & 32'h1) << 31)
                         | (((i >> 1) & 32'h3FF) << 21) | (((i >> 11) & 32'h1) << 20)
                         | (((i >> 12) & 32'hFF) << 12);
            3'd5: return base | (32'(v.rd) << 7) | (32'(v.rs2) << 20) | (32'(v.f7) << 25);
            default: return 32'h0;
        endcase
    endfunction

    // Immediate generator used to confirm the round trip
    function automatic logic [31:0] decode(input logic [2:0] sel, input logic [31:0] w);
        case (sel)
            3'd0: return {{20{w[31]}}, w[31:20]};
            3'd1: return {{20{w[31]}}, w[31:25], w[11:7]};
            3'd2: return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            3'd3: return {w[31:12], 12'h000};
            3'd4: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit range_ok(input vec_t v);
`ifdef IMM_RANGE_CHECK_EN
        int si;
        si = int'($signed(v.imm));
        case (v.sel)
            3'd0, 3'd1: return (si >= -2048) && (si <= 2047);
            3'd2:       return (si >= -4096) && (si <= 4095) && ((v.imm & 32'h1) == 32'h0);
            3'd3:       return (v.imm & 32'hFFF) == 32'h0;
            3'd4:       return (si >= -1048576) && (si <= 1048575) && ((v.imm & 32'h1) == 32'h0);
            default:    return 1'b1;
        endcase
`else
        return (v.sel == v.sel);
`endif
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        v.sel  = 3'($urandom_range(0, 7));
        v.op   = 7'($urandom);
        v.rd   = 5'($urandom);
        v.rs1  = 5'($urandom);
        v.rs2  = 5'($urandom);
        v.f3   = 3'($urandom);
        v.f7   = 7'($urandom);
        case ($urandom_range(0, 3))
            0:       v.imm = $urandom;
            1:       v.imm = $urandom & 32'hFFFFF000;
            2:       v.imm = 32'($urandom_range(0, 6000)) - 32'd3000;
            default: v.imm = (32'($urandom_range(0, 6000)) - 32'd3000) & 32'hFFFFFFFE;
        endcase
        v.word = 32'h0;
        return v;
    endfunction

    // One clock cycle: drive at negedge, predict, compare just after posedge
    task automatic step(input logic st, input logic vld, input vec_t v);
        bit          ready_e;
        bit          acc;
        bit          sel_ok;
        bit          we_e;
        int          addr_e;
        logic [31:0] word_e;
        @(negedge clk);
        start      = st;
        in_valid   = vld;
        in_imm_sel = v.sel;
        in_opcode  = v.op;
        in_rd      = v.rd;
        in_rs1     = v.rs1;
        in_rs2     = v.rs2;
        in_funct3  = v.f3;
        in_funct7  = v.f7;
        in_imm     = v.imm;
        #1;
        ready_e = m_run && !st && (m_count < CAP);
        check("in_ready", 32'(in_ready), 32'(ready_e));
        acc    = vld && ready_e;
        sel_ok = (v.sel <= 3'd5);
        we_e   = acc && sel_ok && range_ok(v);
        addr_e = m_count;
        word_e = ref_word(v);
        if (st) begin
            m_run   = 1;
            m_count = 0;
            m_err   = 0;
            m_code  = 2'b00;
        end else begin
            if (acc && !we_e && !m_err) begin
                m_err  = 1;
                m_code = sel_ok ? 2'b10 : 2'b01;
            end
            if (we_e) m_count++;
        end
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
        check("mem_we", 32'(mem_we), 32'(we_e));
        if (we_e) begin
            check("mem_addr", 32'(mem_addr), 32'(addr_e));
            check("mem_wdata", mem_wdata, word_e);
        end
        check("count", 32'(count), 32'(m_count));
        check("err", 32'(err), 32'(m_err));
        check("err_code", 32'(err_code), 32'(m_code));
    endtask

    initial begin
        idle_v = '{3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'd0};
        tbl[0] = '{3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,  32'd1,          32'h00100093};
        tbl[1] = '{3'd1, 7'h23, 5'd0, 5'd0, 5'd2, 3'd2, 7'd0,  32'd4,          32'h00202223};
        tbl[2] = '{3'd3, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0,  32'h12345000,   32'h123452B7};
        tbl[3] = '{3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,  32'hFFFFFFF8,   32'hFE000CE3};
        tbl[4] = '{3'd4, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,  32'd0,          32'h0000006F};
        tbl[5] = '{3'd5, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0,          32'h002081B3};
        tbl[6] = '{3'd5, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0,          32'h402081B3};

        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
        in_imm_sel = 3'd0; in_opcode = 7'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
        in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = 32'd0;
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // IDLE refuses traffic until start
        step(0, 1, tbl[0]);
        step(1, 1, tbl[0]);

        // directed table with golden words and imm_gen round trip
        for (int i = 0; i < NV; i++) begin
            if (m_count == CAP) step(1, 0, idle_v);
            step(0, 1, tbl[i]);
            check("tbl_word", mem_wdata, tbl[i].word);
            if (tbl[i].sel != 3'd5) check("round_trip", decode(tbl[i].sel, mem_wdata), tbl[i].imm);
        end

        // fill the memory: five offered, four written, then FULL
        step(1, 0, idle_v);
        for (int i = 0; i < 5; i++) step(0, 1, tbl[0]);
        check("full_count", 32'(count), 32'd4);
        check("full_ready", 32'(in_ready), 32'd0);

        // start right after a transfer: pending write lands, count clears
        step(1, 0, idle_v);
        step(0, 1, tbl[1]);
        step(1, 0, idle_v);
        check("restart_count", 32'(count), 32'd0);

        // invalid select is consumed, sticky ERR_SEL survives a range error
        v_tmp = tbl[0];
        v_tmp.sel = 3'd7;
        step(0, 1, v_tmp);
        check("sel_err_code", 32'(err_code), 32'd1);
        v_tmp = tbl[0];
        v_tmp.imm = 32'd2048;
        step(0, 1, v_tmp);
        check("sticky_code", 32'(err_code), 32'd1);
        step(1, 0, idle_v);
        check("start_clears_err", 32'(err), 32'd0);

`ifdef IMM_RANGE_CHECK_EN
        step(0, 1, v_tmp);
        check("range_code", 32'(err_code), 32'd2);
        check("range_no_we", 32'(mem_we), 32'd0);
        step(0, 1, tbl[0]);
        check("after_range_addr", 32'(mem_addr), 32'd0);
        check("after_range_we", 32'(mem_we), 32'd1);
`endif

        // asynchronous reset drops a pending write immediately
        step(1, 0, idle_v);
        step(0, 1, tbl[2]);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_mem_we", 32'(mem_we), 32'd0);
        check("arst_mem_addr", 32'(mem_addr), 32'd0);
        check("arst_mem_wdata", mem_wdata, 32'd0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_err", 32'(err), 32'd0);
        check("arst_err_code", 32'(err_code), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        m_run = 0; m_count = 0; m_err = 0; m_code = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), rand_vec());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Instruction encoder and program loader: the inverse of the immediate generator. Accepts decoded instruction fields plus a 32-bit immediate over a valid/ready handshake and packs them into a 32-bit RV32I word. It writes each packed word to consecutive program-memory addresses, one registered cycle after acceptance. The bench, or a boot/loader path, uses it to build the Fibonacci program image. For any in-range immediate, feeding the written word and the same format select back through the immediate generator must return the original immediate.

## Interface
- ADDR_W, 8, program-memory word-address width; capacity 2**ADDR_W words
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; clears address, count and error; enters RUN
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept this cycle
- in_imm_sel  in  3  format: IMM_I=000, IMM_S=001, IMM_B=010, IMM_U=011, IMM_J=100, IMM_R=101 (no immediate)
- in_opcode  in  7  opcode[6:0]
- in_rd / in_rs1 / in_rs2  in  5 each  register fields
- in_funct3  in  3;  in_funct7  in  7 (R-type only)
- in_imm  in  32  full signed immediate, unshifted byte offset for B/J, full value for U
- mem_we  out  1  one-cycle write strobe
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  32  encoded instruction
- count  out  ADDR_W+1  words written since start
- err  out  1  sticky error
- err_code  out  2  00 none, 01 ERR_SEL, 10 ERR_RANGE; the first error is held

## Operation
- States: IDLE, RUN, FULL. Reset → IDLE. start in any state → RUN. count=0 in RUN and wptr reaching 2**ADDR_W → FULL.
- in_ready = (state==RUN) && !start. A transfer occurs when in_valid && in_ready.
- Packing (fields not listed are ignored):
  - I: imm[11:0], rs1, funct3, rd, opcode
  - S: imm[11:5], rs2, rs1, funct3, imm[4:0], opcode
  - B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode
  - U: imm[31:12], rd, opcode
  - J: imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode
  - R: funct7, rs2, rs1, funct3, rd, opcode
- Invalid sel (110/111): the transfer is consumed, nothing is written, and ERR_SEL is raised.
- Errors: err is set and err_code latched on the first error only. Both are cleared only by start or reset. An error does not halt acceptance.
- count increments on every write. The write pointer is count[ADDR_W-1:0].

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, count=0, err=0, err_code=00.
- Latency: transfer at edge N → mem_we=1 with mem_addr/mem_wdata valid in cycle N+1. count updates at the same edge as the write.
- Throughput: one word per cycle. There is no memory backpressure; the memory accepts every strobe.
- Last slot: the transfer that fills address 2**ADDR_W-1 is written, then the FSM enters FULL. In FULL, in_ready=0.
- start concurrent with in_valid: the transfer is refused, since in_ready=0. start in the cycle after a transfer: the pending write still occurs (at the old address), then count resets to 0.
- Asynchronous reset mid-operation: a pending write is dropped and all outputs return to their reset values immediately.

## Configuration
- IMM_RANGE_CHECK_EN defined: the immediate is checked before writing.
  - I/S: in_imm must be a sign-extended 12-bit value.
  - B: 13-bit signed with imm[0]=0.
  - J: 21-bit signed with imm[0]=0.
  - U: imm[11:0]=0.
  - R: the immediate is not checked.
  - On violation: the transfer is consumed, nothing is written, and ERR_RANGE is raised.
- IMM_RANGE_CHECK_EN undefined: the immediate is truncated silently and always written. ERR_RANGE is never produced.

## Structure
- Shared package: IMM_I/S/B/U/J and IMM_NF (existing); new IMM_R=3'b101; err_code constants ERR_NONE/ERR_SEL/ERR_RANGE; FSM state enum.
- Sub-module imm_pack: combinational field/immediate → word packer plus range-violation flag. The top holds the FSM, the output register and the counter.

## Test plan
- I-type addi x1,x0,1 (opcode 0010011, rd=1, imm=1) after start → cycle N+1: mem_we=1, addr=0, wdata=0x00100093, count=1.
- S-type sw x2,4(x0) then U-type lui x5,0x12345000 back-to-back → 0x00202223 at addr 0, 0x123452B7 at addr 1, on consecutive cycles.
- B-type beq x0,x0,-8 → 0xFE000CE3; J-type jal x0,0 → 0x0000006F. Each word, fed back through imm_gen with the same select, returns -8 and 0 respectively.
- With IMM_RANGE_CHECK_EN: I-type imm=2048 → no mem_we, err=1, err_code=10. A following valid word is still written at addr 0.
- in_imm_sel=111 → no write, err_code=01. A later range error leaves err_code=01. start clears err.
- ADDR_W=2: five transfers offered → four writes at addr 0..3, FSM in FULL, in_ready=0, count=4. Assert rst_n low mid-stream → all outputs 0 asynchronously.
